// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Immediate-format select codes shared by the control unit,
//                the immediate generator and the ImmGen arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

   // ImmSel encodings; every other 3-bit value is illegal
   localparam logic [2:0] IMM_TYPE_I = 3'd1;
   localparam logic [2:0] IMM_TYPE_B = 3'd2;
   localparam logic [2:0] IMM_TYPE_J = 3'd3;
   localparam logic [2:0] IMM_TYPE_S = 3'd4;
   localparam logic [2:0] IMM_TYPE_U = 3'd5;

   // Two-port request vector, bit i = port i
   typedef logic [1:0] port_vec_t;

   // True when sel names one of the five supported immediate formats
   function automatic logic imm_sel_legal(input logic [2:0] sel);
      return (sel >= IMM_TYPE_I) && (sel <= IMM_TYPE_U);
   endfunction

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_share_arb_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : RV32 immediate generator. Decodes I/B/J/S/U immediates from
//                an instruction word; illegal selects yield zero plus err.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
   import imm_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [2:0]  sel,
   output logic [31:0] imm,
   output logic        err
);

   // Opcode bits carry no immediate information
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   // Format-specific bit gathering with sign extension from inst[31]
   always_comb begin
      imm = 32'h0;
      err = !imm_sel_legal(sel);
      case (sel)
         IMM_TYPE_I: imm = {{20{inst[31]}}, inst[31:20]};
         IMM_TYPE_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_TYPE_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
         IMM_TYPE_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
         IMM_TYPE_U: imm = {inst[31:12], 12'h000};
         default:    imm = 32'h0;
      endcase
   end

endmodule : imm_gen
`default_nettype wire

// File: rtl/imm_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : imm_share_arb
//  Description : Shares one ImmGen between ID decode (port 0) and IF branch
//                pre-decode (port 1). Per-cycle arbitration, single-entry
//                registered response buffer returning winner id and tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_share_arb
   import imm_pkg::*;
#(
   parameter int RR    = 1,
   parameter int TAG_W = 5
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req_inst0,
   input  logic [31:0]      req_inst1,
   input  logic [2:0]       req_sel0,
   input  logic [2:0]       req_sel1,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [31:0]      rsp_imm,
   output logic             rsp_err
);

   logic             can_accept;
   logic             both_valid;
   logic             contend_win;
   port_vec_t        grant;
   logic             win;
   logic             rr_ptr;
   logic [31:0]      mux_inst;
   logic [2:0]       mux_sel;
   logic [TAG_W-1:0] mux_tag;
   logic [31:0]      gen_imm;
   logic             gen_err;

   // Buffer can take a new result when empty or draining this cycle
   assign can_accept = !rsp_valid || rsp_ready;
   assign both_valid = req_valid[0] && req_valid[1];

   // Winner under contention depends on the arbitration policy
   if (RR != 0) begin : g_rr
      assign contend_win = rr_ptr;
   end else begin : g_fixed
      logic unused_rr_ptr;
      assign unused_rr_ptr = rr_ptr;
      assign contend_win   = 1'b0;
   end

   // One-hot or zero grant; suppressed during reset and when buffer is full
   always_comb begin
      grant = 2'b00;
      if (rst_n && can_accept) begin
         if (both_valid)
            grant = contend_win ? 2'b10 : 2'b01;
         else
            grant = req_valid;
      end
   end

   assign req_ready = grant;
   assign win       = grant[1];

   assign mux_inst = win ? req_inst1 : req_inst0;
   assign mux_sel  = win ? req_sel1  : req_sel0;
   assign mux_tag  = win ? req_tag1  : req_tag0;

   imm_gen u_imm_gen (
      .inst (mux_inst),
      .sel  (mux_sel),
      .imm  (gen_imm),
      .err  (gen_err)
   );

   // Round-robin pointer moves to the loser only after a contended grant
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= 1'b0;
      else if ((grant != 2'b00) && both_valid)
         rr_ptr <= ~win;
   end

   // Response buffer: load on grant, clear on drain, hold under back-pressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_tag   <= '0;
         rsp_imm   <= 32'h0;
         rsp_err   <= 1'b0;
      end else if (grant != 2'b00) begin
         rsp_valid <= 1'b1;
         rsp_id    <= win;
         rsp_tag   <= mux_tag;
         rsp_imm   <= gen_imm;
         rsp_err   <= gen_err;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule : imm_share_arb
`default_nettype wire
